pc11_tapeq: RTL and testbench

PC11_TAPEQ -- requirements
Module: pc11_tapeq

---
 rtl/pc11_pkg.sv | 34 +++
 rtl/tapeq_fifo.sv | 53 +++++
 rtl/pc11_tapeq.sv | 159 +++++++++++++++
 tb/tb_pc11_tapeq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pc11_pkg.sv
// Shared constants for the PC11 tape queue: ARM register map, pc11 register
// indices, FSM encoding, ID word and the fixed CSR words written back to the pc11.
package pc11_pkg;

  localparam logic [1:0] REG_ID   = 2'd0;
  localparam logic [1:0] REG_CNT  = 2'd1;
  localparam logic [1:0] REG_PDAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam logic [1:0] PC_RCSR = 2'd1;
  localparam logic [1:0] PC_PCSR = 2'd2;

  // 'PQ' in the top half, block type 1 in [15:12], version ORed into [11:0].
  localparam logic [31:0] PQ_ID = 32'h5051_1000;

  localparam logic [31:0] RDR_EOT_WORD  = 32'h0000_8000;
  localparam logic [31:0] PUN_DONE_WORD = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RDWAIT  = 2'd1,
    ST_PUWAIT  = 2'd2,
    ST_PUSTALL = 2'd3
  } state_t;

  function automatic logic [31:0] rdr_word(input logic [7:0] b);
    return {8'h00, b, 8'h00, 8'h80};
  endfunction

  function automatic logic [1:0] next_poll(input logic [1:0] a);
    return (a == PC_RCSR) ? PC_PCSR : PC_RCSR;
  endfunction

endpackage

// File: rtl/tapeq_fifo.sv
// Byte FIFO with occupancy count; push is dropped when full, pop ignored when empty.
// Same-cycle push and pop both take effect and leave the count unchanged.
module tapeq_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pc11_tapeq.sv
// Queues paper-tape bytes between an ARM register port and the pc11 register port,
// polling reader/punch CSRs and completing each character after chartime cycles.
module pc11_tapeq
  import pc11_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [11:0] VERSION = 12'h001
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        pcwrite,
  output logic [1:0]  pcraddr,
  output logic [1:0]  pcwaddr,
  output logic [31:0] pcwdata,
  input  logic [31:0] pcrdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state_q;
  logic          enable_q;
  logic [19:0]   chartime_q, timer_q;
  logic          pcwrite_q;
  logic [1:0]    pcraddr_q, pcwaddr_q;
  logic [31:0]   pcwdata_q;

  logic          arm_push, arm_pop, ctrl_wr, flush;
  logic          rd_busy, pu_busy, expire, rd_pop, pu_fire;
  logic [7:0]    r_dout, p_dout, phead;
  logic          r_full, r_empty, p_full, p_empty;
  logic [CW-1:0] r_count, p_count;
  logic          unused_bits;

  assign arm_push = armwrite && (armwaddr == REG_CNT);
  assign arm_pop  = armwrite && (armwaddr == REG_PDAT);
  assign ctrl_wr  = armwrite && (armwaddr == REG_CTRL);
  assign flush    = ctrl_wr && armwdata[30];

  assign rd_busy = pcrdata[11];
  assign pu_busy = !pcrdata[7];
  assign expire  = (timer_q == '0);
  assign rd_pop  = enable_q && (state_q == ST_RDWAIT) && expire && rd_busy && !r_empty;
  assign pu_fire = enable_q && !p_full &&
                   (((state_q == ST_PUWAIT) && expire && pu_busy) || (state_q == ST_PUSTALL));

  assign phead       = p_empty ? 8'h00 : p_dout;
  assign unused_bits = ^{pcrdata[31:24], pcrdata[14:12], pcrdata[10:8], pcrdata[6:0],
                         armwdata[29:20], r_full};

  tapeq_fifo #(.DEPTH(DEPTH)) u_rdr_fifo (
    .clk_i(CLOCK), .rst_i(RESET), .flush_i(flush),
    .push_i(arm_push), .din_i(armwdata[7:0]), .pop_i(rd_pop),
    .dout_o(r_dout), .full_o(r_full), .empty_o(r_empty), .count_o(r_count)
  );

  tapeq_fifo #(.DEPTH(DEPTH)) u_pun_fifo (
    .clk_i(CLOCK), .rst_i(RESET), .flush_i(flush),
    .push_i(pu_fire), .din_i(pcrdata[23:16]), .pop_i(arm_pop),
    .dout_o(p_dout), .full_o(p_full), .empty_o(p_empty), .count_o(p_count)
  );

  always_comb begin
    armrdata = '0;
    case (armraddr)
      REG_ID:   armrdata = PQ_ID | {20'h0, VERSION};
      REG_CNT:  armrdata = {11'b0, 5'(r_count), 11'b0, 5'(p_count)};
      REG_PDAT: armrdata = {23'b0, !p_empty, phead};
      default:  armrdata = {enable_q, 11'b0, chartime_q};
    endcase
  end

  // pcraddr is held on the CSR under test while waiting so pcrdata re-checks it at expiry.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      chartime_q <= '0;
      timer_q    <= '0;
      pcwrite_q  <= 1'b0;
      pcwaddr_q  <= '0;
      pcwdata_q  <= '0;
      pcraddr_q  <= PC_RCSR;
    end else begin
      pcwrite_q <= 1'b0;
      if (ctrl_wr) begin
        enable_q   <= armwdata[31];
        chartime_q <= armwdata[19:0];
      end
      if (!enable_q) begin
        state_q   <= ST_IDLE;
        pcraddr_q <= (state_q == ST_IDLE) ? next_poll(pcraddr_q) : PC_RCSR;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (pcraddr_q == PC_RCSR && rd_busy) begin
              state_q <= ST_RDWAIT;
              timer_q <= chartime_q;
            end else if (pcraddr_q == PC_PCSR && pu_busy && !pcrdata[15]) begin
              state_q <= ST_PUWAIT;
              timer_q <= chartime_q;
            end else begin
              pcraddr_q <= next_poll(pcraddr_q);
            end
          end
          ST_RDWAIT: begin
            if (!expire) begin
              timer_q <= timer_q - 20'd1;
            end else begin
              state_q   <= ST_IDLE;
              pcraddr_q <= PC_PCSR;
              if (rd_busy) begin
                pcwrite_q <= 1'b1;
                pcwaddr_q <= PC_RCSR;
                pcwdata_q <= r_empty ? RDR_EOT_WORD : rdr_word(r_dout);
              end
            end
          end
          ST_PUWAIT: begin
            if (!expire) begin
              timer_q <= timer_q - 20'd1;
            end else if (!pu_busy) begin
              state_q   <= ST_IDLE;
              pcraddr_q <= PC_RCSR;
            end else if (p_full) begin
              state_q <= ST_PUSTALL;
            end else begin
              state_q   <= ST_IDLE;
              pcraddr_q <= PC_RCSR;
              pcwrite_q <= 1'b1;
              pcwaddr_q <= PC_PCSR;
              pcwdata_q <= PUN_DONE_WORD;
            end
          end
          ST_PUSTALL: begin
            if (!p_full) begin
              state_q   <= ST_IDLE;
              pcraddr_q <= PC_RCSR;
              pcwrite_q <= 1'b1;
              pcwaddr_q <= PC_PCSR;
              pcwdata_q <= PUN_DONE_WORD;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign pcwrite = pcwrite_q;
  assign pcraddr = pcraddr_q;
  assign pcwaddr = pcwaddr_q;
  assign pcwdata = pcwdata_q;

endmodule

// File: tb/tb_pc11_tapeq.sv
// Scoreboard bench for pc11_tapeq: a small pc11 CSR model answers reads and absorbs
// completion writes; expected pc11 writes are queued and checked by a monitor.
module tb_pc11_tapeq;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = 32'h0;
  logic [31:0] armrdata;
  logic        pcwrite;
  logic [1:0]  pcraddr, pcwaddr;
  logic [31:0] pcwdata, pcrdata;

  logic [31:0] rcsr = 32'h0000_0000;
  logic [31:0] pcsr = 32'h0000_0080;

  int checks = 0, failures = 0;
  int cyc = 0, wr_cnt = 0, last_wr_cyc = 0, last_arm_cyc = 0;
  logic [33:0] exp_q[$];

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc++;

  assign pcrdata = (pcraddr == 2'd1) ? rcsr : (pcraddr == 2'd2) ? pcsr : 32'h0;

  pc11_tapeq dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .pcwrite(pcwrite), .pcraddr(pcraddr), .pcwaddr(pcwaddr),
    .pcwdata(pcwdata), .pcrdata(pcrdata)
  );

  // Monitor: every pc11 write is matched against the head of the expected queue,
  // then applied to the CSR model the way the pc11 would latch it.
  always @(negedge CLOCK) begin
    if (pcwrite === 1'b1) begin
      logic [33:0] e;
      wr_cnt++;
      last_wr_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pcwrite_unexpected actual=%0d:%h required=no write", pcwaddr, pcwdata);
      end else begin
        e = exp_q.pop_front();
        if ({pcwaddr, pcwdata} !== e) begin
          failures++;
          $display("FAIL pcwrite actual=%0d:%h required=%0d:%h", pcwaddr, pcwdata, e[33:32], e[31:0]);
        end
      end
      if (pcwaddr == 2'd1) rcsr[11] = pcwdata[11];
      else if (pcwaddr == 2'd2) pcsr[7] = pcwdata[7];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge CLOCK);
    armwrite = 1'b1;
    armwaddr = a;
    armwdata = d;
    @(negedge CLOCK);
    armwrite = 1'b0;
    last_arm_cyc = cyc;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] req, input string name);
    @(negedge CLOCK);
    armraddr = a;
    #1;
    chk(name, 64'(armrdata), 64'(req));
  endtask

  task automatic expect_wr(input logic [1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wait_wr(input int n, input int budget, input string name);
    int k = 0;
    while (wr_cnt < n && k < budget) begin
      @(negedge CLOCK);
      k++;
    end
    chk(name, 64'(wr_cnt), 64'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, lat;
    logic [7:0] b;

    // Reset state, sampled while RESET is still held.
    RESET = 1'b1;
    idle(3);
    chk("rst_pcwrite", 64'(pcwrite), 64'd0);
    chk("rst_pcwaddr", 64'(pcwaddr), 64'd0);
    chk("rst_pcwdata", 64'(pcwdata), 64'd0);
    chk("rst_pcraddr", 64'(pcraddr), 64'd1);
    rd_chk(2'd0, 32'h5051_1001, "id_reg");
    rd_chk(2'd1, 32'h0000_0000, "rst_counts");
    rd_chk(2'd2, 32'h0000_0000, "rst_pdata");
    rd_chk(2'd3, 32'h0000_0000, "rst_ctrl");
    @(negedge CLOCK);
    RESET = 1'b0;

    // Reader character 8'o215 with chartime 100.
    rcsr = 32'h0000_0800;
    arm_wr(2'd1, 32'h0000_008D);
    rd_chk(2'd1, 32'h0001_0000, "rcount_after_push");
    expect_wr(2'd1, 32'h008D_0080);
    arm_wr(2'd3, 32'h8000_0064);
    rd_chk(2'd3, 32'h8000_0064, "ctrl_readback");
    base = last_arm_cyc;
    wait_wr(1, 200, "rd_char_wr_count");
    lat = last_wr_cyc - base;
    checks++;
    if (lat < 102 || lat > 103) begin
      failures++;
      $display("FAIL rd_char_latency actual=%0d required=102..103", lat);
    end
    rd_chk(2'd1, 32'h0000_0000, "rcount_after_pop");

    // Reader busy with empty FIFO: out-of-tape write, no pop.
    arm_wr(2'd3, 32'h8000_0005);
    expect_wr(2'd1, 32'h0000_8000);
    rcsr = 32'h0000_0800;
    wait_wr(2, 50, "rd_eot_wr_count");
    rd_chk(2'd1, 32'h0000_0000, "rcount_eot");

    // Punch character 8'h41 with chartime 0, then ARM pop.
    arm_wr(2'd3, 32'h8000_0000);
    expect_wr(2'd2, 32'h0000_0080);
    pcsr = 32'h0041_0000;
    wait_wr(3, 20, "pu_char_wr_count");
    rd_chk(2'd2, 32'h0000_0141, "pdata_valid");
    rd_chk(2'd1, 32'h0000_0001, "pcount_one");
    arm_wr(2'd2, 32'h0);
    rd_chk(2'd2, 32'h0000_0000, "pdata_popped");

    // Fill punch FIFO with 8'h10..8'h1F, then stall on a full FIFO.
    for (int i = 0; i < 16; i++) begin
      expect_wr(2'd2, 32'h0000_0080);
      b = 8'(16 + i);
      pcsr = {8'h00, b, 16'h0000};
      wait_wr(4 + i, 20, "pu_fill_wr_count");
    end
    rd_chk(2'd1, 32'h0000_0010, "pcount_full");
    pcsr = 32'h0055_0000;
    idle(10);
    chk("stall_nowrite", 64'(wr_cnt), 64'd19);
    chk("stall_pcsr_done", 64'(pcsr[7]), 64'd0);
    expect_wr(2'd2, 32'h0000_0080);
    arm_wr(2'd2, 32'h0);
    base = last_arm_cyc;
    wait_wr(20, 10, "stall_release_wr_count");
    chk("stall_release_latency", 64'(last_wr_cyc - base), 64'd1);
    rd_chk(2'd1, 32'h0000_0010, "pcount_refill");
    rd_chk(2'd2, 32'h0000_0111, "phead_after_pop");
    arm_wr(2'd3, 32'h4000_0000);
    rd_chk(2'd1, 32'h0000_0000, "flush_counts");
    rd_chk(2'd3, 32'h0000_0000, "flush_ctrl");

    // Reader busy drops during the wait: no write, byte kept.
    arm_wr(2'd1, 32'h0000_0033);
    arm_wr(2'd3, 32'h8000_0014);
    rcsr = 32'h0000_0800;
    idle(6);
    rcsr = 32'h0000_0000;
    idle(30);
    chk("rd_abort_nowrite", 64'(wr_cnt), 64'd20);
    rd_chk(2'd1, 32'h0001_0000, "rd_abort_rcount");

    // Reset during a punch wait: aborted, no write.
    pcsr = 32'h0077_0000;
    idle(6);
    @(negedge CLOCK);
    RESET = 1'b1;
    idle(2);
    chk("midrst_pcraddr", 64'(pcraddr), 64'd1);
    chk("midrst_pcwrite", 64'(pcwrite), 64'd0);
    @(negedge CLOCK);
    RESET = 1'b0;
    idle(30);
    chk("rst_abort_nowrite", 64'(wr_cnt), 64'd20);
    rd_chk(2'd3, 32'h0000_0000, "rst_abort_ctrl");
    rd_chk(2'd1, 32'h0000_0000, "rst_abort_counts");

    // Reader FIFO overflow: 17th byte dropped.
    for (int i = 0; i < 17; i++) arm_wr(2'd1, 32'(i));
    rd_chk(2'd1, 32'h0010_0000, "rdr_overflow_drop");

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
